// File: rtl/core_pkg.sv
// Shared core definitions: load width/sign codes and architectural constants.
package core_pkg;

    typedef enum logic [2:0] {
        LT_W  = 3'd0,
        LT_B  = 3'd1,
        LT_BU = 3'd2,
        LT_H  = 3'd3,
        LT_HU = 3'd4
    } load_type_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load lane select and sign/zero extension (combinational).
module load_align
    import core_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane; reserved codes behave as a full word
    always_comb begin
        data = word;
        case (load_type)
            LT_B:    data = {{24{byte_s[7]}}, byte_s};
            LT_BU:   data = {24'h000000, byte_s};
            LT_H:    data = {{16{half_s[15]}}, half_s};
            LT_HU:   data = {16'h0000, half_s};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback formatter and retire counter.
// Define WB_BYPASS_EN to add the same-cycle regfile write-to-read bypass ports.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             m_valid,
    input  logic             m_regwrite,
    input  logic             m_memtoreg,
    input  logic [2:0]       m_load_type,
    input  logic [AW-1:0]    m_wa,
    input  logic [DW-1:0]    m_alu_result,
    input  logic [DW-1:0]    m_read_data,
    input  logic [DW-1:0]    m_pc,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [DW-1:0]    rf_rd1,
    input  logic [DW-1:0]    rf_rd2,
    output logic [DW-1:0]    byp_rd1,
    output logic [DW-1:0]    byp_rd2,
`endif
    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [DW-1:0]    wd3,
    output logic             w_valid,
    output logic [DW-1:0]    w_pc,
    output logic [CNT_W-1:0] retire_cnt
);

    logic             valid_r;
    logic             we_r;
    logic [AW-1:0]    wa_r;
    logic [DW-1:0]    wd_r;
    logic [DW-1:0]    pc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    load_ext_s;
    logic [DW-1:0]    wd_next_s;
    logic             we_next_s;

    load_align u_load_align (
        .word      (m_read_data),
        .off       (m_alu_result[1:0]),
        .load_type (m_load_type),
        .data      (load_ext_s)
    );

    // Formatting is done before the register so that wd3/we3 come straight from flops
    always_comb begin
        we_next_s = m_valid & m_regwrite & (m_wa != REG_ZERO);
        if (m_memtoreg) begin
            wd_next_s = load_ext_s;
        end else begin
            wd_next_s = m_alu_result;
        end
    end

    // Pipeline register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            valid_r <= 1'b0;
            we_r    <= 1'b0;
            wa_r    <= '0;
            wd_r    <= '0;
            pc_r    <= '0;
        end else if (!stall_w) begin
            valid_r <= m_valid;
            we_r    <= we_next_s;
            wa_r    <= m_wa;
            wd_r    <= wd_next_s;
            pc_r    <= m_pc;
        end
    end

    // A WB instruction retires when it leaves the stage, even if a flush arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (valid_r && !stall_w) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign we3        = we_r;
    assign wa3        = wa_r;
    assign wd3        = wd_r;
    assign w_valid    = valid_r;
    assign w_pc       = pc_r;
    assign retire_cnt = cnt_r;

`ifdef WB_BYPASS_EN
    assign byp_rd1 = (we_r && (ra1 == wa_r)) ? wd_r : rf_rd1;
    assign byp_rd2 = (we_r && (ra2 == wa_r)) ? wd_r : rf_rd2;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst, stall_w, flush_w, m_valid, m_regwrite, m_memtoreg;
    logic [2:0]  m_load_type;
    logic [4:0]  m_wa;
    logic [31:0] m_alu_result, m_read_data, m_pc;
    logic we3, w_valid;
    logic [4:0]  wa3;
    logic [31:0] wd3, w_pc;
    logic [CW-1:0] retire_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  ra1, ra2;
    logic [31:0] rf_rd1, rf_rd2, byp_rd1, byp_rd2;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(32), .AW(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_load_type(m_load_type), .m_wa(m_wa), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_pc(m_pc),
`ifdef WB_BYPASS_EN
        .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
`endif
        .we3(we3), .wa3(wa3), .wd3(wd3), .w_valid(w_valid), .w_pc(w_pc),
        .retire_cnt(retire_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: raw instruction held in WB, extension computed from the load rules
    logic        md_ok = 1'b0;
    logic        md_valid, md_rw, md_mtr;
    logic [2:0]  md_lt;
    logic [4:0]  md_wa;
    logic [31:0] md_alu, md_rd, md_pc;
    int          md_cnt;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] lt);
        logic [31:0] b, h;
        b = w >> (8 * off);
        h = w >> (16 * off[1]);
        if (lt == 3'd1) return {{24{b[7]}}, b[7:0]};
        if (lt == 3'd2) return {24'd0, b[7:0]};
        if (lt == 3'd3) return {{16{h[15]}}, h[15:0]};
        if (lt == 3'd4) return {16'd0, h[15:0]};
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md_ok <= 1'b1;
            md_cnt <= 0;
        end else if (md_valid && !stall_w) begin
            md_cnt <= (md_cnt + 1) % (1 << CW);
        end
        if (rst || flush_w) begin
            md_valid <= 1'b0; md_rw <= 1'b0; md_mtr <= 1'b0; md_lt <= 3'd0;
            md_wa <= 5'd0; md_alu <= 32'd0; md_rd <= 32'd0; md_pc <= 32'd0;
        end else if (!stall_w) begin
            md_valid <= m_valid; md_rw <= m_regwrite; md_mtr <= m_memtoreg;
            md_lt <= m_load_type; md_wa <= m_wa; md_alu <= m_alu_result;
            md_rd <= m_read_data; md_pc <= m_pc;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (md_ok) begin
            chk("w_valid", {31'd0, w_valid}, {31'd0, md_valid});
            chk("we3", {31'd0, we3}, {31'd0, md_valid && md_rw && md_wa != 5'd0});
            chk("wa3", {27'd0, wa3}, {27'd0, md_wa});
            chk("wd3", wd3, md_mtr ? ext(md_rd, md_alu[1:0], md_lt) : md_alu);
            chk("w_pc", w_pc, md_pc);
            chk("retire_cnt", {24'd0, retire_cnt}, md_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [2:0] lt,
                         input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pc);
        m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_load_type = lt;
        m_wa = wa; m_alu_result = alu; m_read_data = rd; m_pc = pc;
    endtask

    logic [2:0]  lt_tab  [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  off_tab [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp_tab [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        int c0;
        logic [31:0] a_wd;
        rst = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
`ifdef WB_BYPASS_EN
        ra1 = 5'd0; ra2 = 5'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
`endif
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd7, 32'h1111_1111, 32'd0, 32'h100);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_we3", {31'd0, we3}, 32'd0);
            chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
            chk("rst_wd3", wd3, 32'd0);
            chk("rst_cnt", {24'd0, retire_cnt}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rel_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rel_cnt", {24'd0, retire_cnt}, 32'd0);

        // ALU writeback
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd8, 32'h1234_5678, 32'd0, 32'h200);
        step();
        chk("alu_we3", {31'd0, we3}, 32'd1);
        chk("alu_wa3", {27'd0, wa3}, 32'd8);
        chk("alu_wd3", wd3, 32'h1234_5678);
        chk("alu_cnt0", {24'd0, retire_cnt}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("alu_cnt1", {24'd0, retire_cnt}, 32'd1);

        // Load extension table
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, lt_tab[i], 5'd3, {30'h400, off_tab[i]}, 32'h80FF_7F01, 32'h300);
            step();
            chk($sformatf("load_ext%0d", i), wd3, exp_tab[i]);
        end

        // $0 suppression
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'h400);
        step();
        c0 = int'(retire_cnt);
        chk("zero_we3", {31'd0, we3}, 32'd0);
        chk("zero_w_valid", {31'd0, w_valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        chk("zero_cnt", {24'd0, retire_cnt}, (c0 + 1) % (1 << CW));

        // Stall three cycles, then flush while stalled
        drive(1'b1, 1'b1, 1'b1, 3'd3, 5'd5, 32'h0000_0002, 32'h8001_0000, 32'h500);
        step();
        a_wd = 32'hFFFF_8001;
        c0 = int'(retire_cnt);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd6, 32'h5555_5555, 32'd0, 32'h504);
        stall_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_we3", {31'd0, we3}, 32'd1);
            chk("stall_wa3", {27'd0, wa3}, 32'd5);
            chk("stall_wd3", wd3, a_wd);
            chk("stall_cnt", {24'd0, retire_cnt}, c0);
        end
        flush_w = 1'b1;
        step();
        chk("flush_w_valid", {31'd0, w_valid}, 32'd0);
        chk("flush_we3", {31'd0, we3}, 32'd0);
        stall_w = 1'b0; flush_w = 1'b0;

`ifdef WB_BYPASS_EN
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'hAAAA_5555, 32'd0, 32'h600);
        step();
        ra1 = 5'd9; rf_rd1 = 32'd0; ra2 = 5'd0; rf_rd2 = 32'd0;
        #1;
        chk("byp_rd1", byp_rd1, 32'hAAAA_5555);
        chk("byp_rd2", byp_rd2, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            stall_w = ($urandom_range(0, 4) == 0);
            flush_w = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            step();
        end

        // Counter wrap (narrow counter instance)
        rst = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd1, 32'h1, 32'd0, 32'h700);
        for (int i = 0; i < (1 << CW); i++) step();
        chk("cnt_max", {24'd0, retire_cnt}, 32'h0000_00FF);
        step();
        chk("cnt_wrap", {24'd0, retire_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
